// File: rtl/serial_link_cfg_seq_pkg.sv
// Shared types and bring-up step constants for the serial link config sequencer.
// Default regbus request/response structs follow the REG_BUS_TYPEDEF_ALL field layout.
package serial_link_cfg_seq_pkg;

  localparam int unsigned DefaultAddrWidth = 32;
  localparam int unsigned DefaultDataWidth = 32;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_POLL  = 2'd1,
    OP_WAIT  = 2'd2
  } op_e;

  typedef struct packed {
    op_e                         op;
    logic [DefaultAddrWidth-1:0] addr;
    logic [DefaultDataWidth-1:0] data;
    logic [DefaultDataWidth-1:0] mask;
  } step_t;

  typedef struct packed {
    logic [DefaultAddrWidth-1:0]   addr;
    logic                          write;
    logic [DefaultDataWidth-1:0]   wdata;
    logic [DefaultDataWidth/8-1:0] wstrb;
    logic                          valid;
  } cfg_req_default_t;

  typedef struct packed {
    logic [DefaultDataWidth-1:0] rdata;
    logic                        error;
    logic                        ready;
  } cfg_rsp_default_t;

  // Serial link config register map used by the standard bring-up.
  localparam logic [DefaultAddrWidth-1:0] CtrlRegAddr       = 32'h0000_0000;
  localparam logic [DefaultAddrWidth-1:0] IsolateRegAddr    = 32'h0000_0004;
  localparam logic [DefaultAddrWidth-1:0] IsoStatusRegAddr  = 32'h0000_0008;

  localparam step_t StepClkEnable = '{op: OP_WRITE, addr: CtrlRegAddr,
                                      data: 32'h0000_0001, mask: 32'hFFFF_FFFF};
  localparam step_t StepRstRelease = '{op: OP_WRITE, addr: CtrlRegAddr,
                                       data: 32'h0000_0003, mask: 32'hFFFF_FFFF};
  localparam step_t StepIsoClear = '{op: OP_WRITE, addr: IsolateRegAddr,
                                     data: 32'h0000_0000, mask: 32'hFFFF_FFFF};
  // Isolation is released once both in/out isolated flags read back as zero.
  localparam step_t StepPollIsolated = '{op: OP_POLL, addr: IsoStatusRegAddr,
                                         data: 32'h0000_0000, mask: 32'h0000_0003};

  localparam int unsigned BringUpNumSteps = 4;
  localparam step_t BringUpSteps [BringUpNumSteps] = '{
    StepClkEnable, StepRstRelease, StepIsoClear, StepPollIsolated
  };

endpackage

// File: rtl/serial_link_cfg_seq.sv
// Regbus initiator that walks a fixed WRITE/POLL/WAIT step list on the serial link
// config port and reports done or the index of the failing step.
module serial_link_cfg_seq
  import serial_link_cfg_seq_pkg::*;
#(
  parameter int unsigned RegAddrWidth       = 32,
  parameter int unsigned RegDataWidth       = 32,
  parameter int unsigned NumSteps           = 4,
  parameter step_t       Steps [NumSteps]   = '{default: '0},
  parameter int unsigned MaxPolls           = 256,
  parameter type         cfg_req_t          = cfg_req_default_t,
  parameter type         cfg_rsp_t          = cfg_rsp_default_t,
  localparam int unsigned IdxW              = $clog2(NumSteps) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [IdxW-1:0] err_step_o,
  output cfg_req_t        cfg_req_o,
  input  cfg_rsp_t        cfg_rsp_i
);

  localparam int unsigned SelW = (NumSteps > 1) ? $clog2(NumSteps) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StError} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [RegDataWidth-1:0] cnt_q, cnt_d;
  cfg_req_t                req_q, req_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [IdxW-1:0]         err_step_q, err_step_d;

  logic [SelW-1:0] cur_sel, nxt_sel;
  step_t           cur_step, nxt_step;
  logic            xfer, last_step, poll_hit, wait_over, poll_timeout;
  logic            step_done, from_wait;

  function automatic cfg_req_t issue_req(step_t s);
    cfg_req_t r;
    r       = '0;
    r.addr  = s.addr;
    r.valid = 1'b1;
    if (s.op == OP_WRITE) begin
      r.write = 1'b1;
      r.wdata = s.data;
      r.wstrb = '1;
    end
    return r;
  endfunction

  assign last_step    = (idx_q == IdxW'(NumSteps - 1));
  assign cur_sel      = SelW'(idx_q);
  assign nxt_sel      = last_step ? cur_sel : SelW'(idx_q + 1'b1);
  assign cur_step     = Steps[cur_sel];
  assign nxt_step     = Steps[nxt_sel];
  assign xfer         = req_q.valid & cfg_rsp_i.ready;
  assign poll_hit     = ((cfg_rsp_i.rdata & cur_step.mask) == (cur_step.data & cur_step.mask));
  assign poll_timeout = (cnt_q == RegDataWidth'(MaxPolls - 1));
  assign wait_over    = (cur_step.data == '0) || (cnt_q == cur_step.data - 1'b1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    done_d     = done_q;
    error_d    = error_q;
    err_step_d = err_step_q;
    step_done  = 1'b0;
    from_wait  = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          idx_d      = '0;
          cnt_d      = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_step_d = '0;
          if (Steps[0].op == OP_WAIT) begin
            state_d = StWait;
            req_d   = '0;
          end else begin
            state_d = StIssue;
            req_d   = issue_req(Steps[0]);
          end
        end
      end
      StIssue: begin
        // valid is low here only for the mandatory gap after a completed transfer
        if (!req_q.valid) begin
          req_d = issue_req(cur_step);
        end else if (xfer) begin
          req_d = '0;
          if (cfg_rsp_i.error ||
              ((cur_step.op != OP_WRITE) && !poll_hit && poll_timeout)) begin
            state_d    = StError;
            error_d    = 1'b1;
            err_step_d = idx_q;
          end else if ((cur_step.op == OP_WRITE) || poll_hit) begin
            step_done = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWait: begin
        if (wait_over) begin
          step_done = 1'b1;
          from_wait = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (step_done) begin
      cnt_d = '0;
      if (last_step) begin
        state_d = StDone;
        done_d  = 1'b1;
        req_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
        if (nxt_step.op == OP_WAIT) begin
          state_d = StWait;
          req_d   = '0;
        end else begin
          state_d = StIssue;
          // Bus has already been idle during a WAIT, so issue without another gap.
          req_d   = from_wait ? issue_req(nxt_step) : '0;
        end
      end
    end

    busy_d = (state_d == StIssue) || (state_d == StWait);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      req_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_step_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_step_q <= err_step_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign err_step_o = err_step_q;
  assign cfg_req_o  = req_q;

endmodule

// File: tb/tb_serial_link_cfg_seq.sv
// Directed bench: 6-step list (WRITE, WRITE, WAIT 5, POLL, WAIT 0, WRITE) against a
// 2-cycle-latency responder whose read data and error injection are steered per run.
module tb_serial_link_cfg_seq;
  import serial_link_cfg_seq_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } cfg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } cfg_rsp_t;

  localparam step_t TbSteps [6] = '{
    '{op: OP_WRITE, addr: 32'h00, data: 32'h1,  mask: 32'hFFFF_FFFF},
    '{op: OP_WRITE, addr: 32'h04, data: 32'h3,  mask: 32'hFFFF_FFFF},
    '{op: OP_WAIT,  addr: 32'h00, data: 32'h5,  mask: 32'h0},
    '{op: OP_POLL,  addr: 32'h08, data: 32'h1,  mask: 32'h1},
    '{op: OP_WAIT,  addr: 32'h00, data: 32'h0,  mask: 32'h0},
    '{op: OP_WRITE, addr: 32'h0C, data: 32'hA5, mask: 32'hFFFF_FFFF}
  };

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       busy_o, done_o, error_o;
  logic [3:0] err_step_o;
  cfg_req_t   cfg_req;
  cfg_rsp_t   cfg_rsp = '0;

  serial_link_cfg_seq #(
    .RegAddrWidth(32),
    .RegDataWidth(32),
    .NumSteps    (6),
    .Steps       (TbSteps),
    .MaxPolls    (4),
    .cfg_req_t   (cfg_req_t),
    .cfg_rsp_t   (cfg_rsp_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .error_o   (error_o),
    .err_step_o(err_step_o),
    .cfg_req_o (cfg_req),
    .cfg_rsp_i (cfg_rsp)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Responder state and transfer log.
  int          vcyc = 0, idle = 0, cur_gap = 0, nxfer = 0, nread = 0;
  int          poll_mode = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  int          x_gap [16], x_len [16];
  logic        x_wr [16];
  logic [31:0] x_addr [16], x_wdata [16];
  logic [3:0]  x_wstrb [16];

  always @(negedge clk) begin
    cfg_rsp = '0;
    if (cfg_req.valid) begin
      if (vcyc == 0) begin
        cur_gap = idle;
        idle    = 0;
      end
      vcyc++;
      if (vcyc >= 2) begin
        cfg_rsp.ready = 1'b1;
        cfg_rsp.error = err_en && (cfg_req.addr == err_addr);
        if (!cfg_req.write) begin
          cfg_rsp.rdata = (poll_mode == 0 && nread >= 2) ? 32'h3 : 32'h0;
          nread++;
        end
        if (nxfer < 16) begin
          x_gap[nxfer]   = cur_gap;
          x_len[nxfer]   = vcyc;
          x_wr[nxfer]    = cfg_req.write;
          x_addr[nxfer]  = cfg_req.addr;
          x_wdata[nxfer] = cfg_req.wdata;
          x_wstrb[nxfer] = cfg_req.wstrb;
        end
        nxfer++;
      end
    end else begin
      vcyc = 0;
      idle++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    nxfer = 0;
    nread = 0;
    for (int i = 0; i < 16; i++) begin
      x_gap[i] = -1; x_len[i] = -1; x_wr[i] = 1'bx;
      x_addr[i] = 'x; x_wdata[i] = 'x; x_wstrb[i] = 'x;
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 300; i++) begin
      if (done_o || error_o) break;
      tick();
    end
  endtask

  initial begin
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_err_step", err_step_o, 0);
    check("rst_req", 128'(cfg_req), 0);

    // Run 1: full list, poll returns 0, 0, 3.
    clear_log();
    poll_mode = 0;
    pulse_start();
    check("r1_valid_after_start", cfg_req.valid, 1);
    check("r1_busy_after_start", busy_o, 1);
    wait_end();
    check("r1_done", done_o, 1);
    check("r1_error", error_o, 0);
    check("r1_busy_end", busy_o, 0);
    check("r1_err_step", err_step_o, 0);
    check("r1_nxfer", nxfer, 6);
    check("r1_nread", nread, 3);
    check("r1_w0_addr", x_addr[0], 32'h0);
    check("r1_w0_wdata", x_wdata[0], 32'h1);
    check("r1_w0_wstrb", x_wstrb[0], 4'hF);
    check("r1_w0_len", x_len[0], 2);
    check("r1_w1_addr", x_addr[1], 32'h4);
    check("r1_w1_wdata", x_wdata[1], 32'h3);
    check("r1_w1_wstrb", x_wstrb[1], 4'hF);
    check("r1_w1_len", x_len[1], 2);
    check("r1_w1_gap", x_gap[1], 1);
    check("r1_wait5_gap", x_gap[2], 5);
    check("r1_rd_write", x_wr[2], 0);
    check("r1_rd_addr", x_addr[2], 32'h8);
    check("r1_rd_wstrb", x_wstrb[2], 4'h0);
    check("r1_rd_wdata", x_wdata[2], 32'h0);
    check("r1_rd2_gap", x_gap[3], 1);
    check("r1_rd3_gap", x_gap[4], 1);
    check("r1_wait0_gap", x_gap[5], 1);
    check("r1_w5_addr", x_addr[5], 32'hC);
    check("r1_w5_wdata", x_wdata[5], 32'hA5);

    // Run 2: poll never matches, MaxPolls=4 -> timeout on step 3.
    clear_log();
    poll_mode = 1;
    pulse_start();
    check("r2_done_cleared", done_o, 0);
    wait_end();
    check("r2_error", error_o, 1);
    check("r2_done", done_o, 0);
    check("r2_err_step", err_step_o, 3);
    check("r2_busy", busy_o, 0);
    repeat (10) tick();
    check("r2_nread", nread, 4);
    check("r2_nxfer", nxfer, 6);
    check("r2_error_held", error_o, 1);

    // Run 3: bus error on step 1 write.
    clear_log();
    poll_mode = 0;
    err_en    = 1'b1;
    err_addr  = 32'h4;
    pulse_start();
    wait_end();
    check("r3_error", error_o, 1);
    check("r3_err_step", err_step_o, 1);
    repeat (10) tick();
    check("r3_nxfer", nxfer, 2);
    check("r3_nread", nread, 0);

    // Run 4: restart from ERROR clears status and reruns from step 0.
    clear_log();
    err_en = 1'b0;
    pulse_start();
    check("r4_error_cleared", error_o, 0);
    check("r4_err_step_cleared", err_step_o, 0);
    check("r4_addr_step0", cfg_req.addr, 32'h0);
    wait_end();
    check("r4_done", done_o, 1);
    check("r4_nxfer", nxfer, 6);

    // Run 5: start while busy is ignored.
    clear_log();
    pulse_start();
    repeat (4) tick();
    check("r5_busy_mid", busy_o, 1);
    pulse_start();
    wait_end();
    check("r5_done", done_o, 1);
    check("r5_nxfer", nxfer, 6);

    // Run 6: reset with valid high and ready low.
    clear_log();
    pulse_start();
    check("r6_valid_before_rst", cfg_req.valid, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("r6_req_after_rst", 128'(cfg_req), 0);
    check("r6_busy_after_rst", busy_o, 0);
    check("r6_done_after_rst", done_o, 0);
    check("r6_error_after_rst", error_o, 0);
    repeat (5) tick();
    check("r6_still_idle", cfg_req.valid, 0);
    check("r6_nxfer", nxfer, 0);

    // Run 7: start and reset together -> reset wins.
    pulse_start();
    wait_end();
    check("r7_done_before", done_o, 1);
    start_i = 1'b1;
    rst_i   = 1'b1;
    tick();
    start_i = 1'b0;
    rst_i   = 1'b0;
    check("r7_done_after", done_o, 0);
    check("r7_busy_after", busy_o, 0);
    repeat (3) tick();
    check("r7_valid_idle", cfg_req.valid, 0);
    check("r7_busy_idle", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
